// File: rtl/sdrc_app_arb.sv
// Multi-channel application arbiter in front of the SDRAM controller core.
// Round-robin request grant, write-data ownership, and read-return routing via a tag FIFO.
module sdrc_app_arb #(
  parameter int NUM_CH    = 4,
  parameter int APP_AW    = 26,
  parameter int dw        = 32,
  parameter int bl        = 9,
  parameter int RDQ_DEPTH = 4
) (
  input  logic                     sdram_clk,
  input  logic                     sdram_rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*APP_AW-1:0] ch_req_addr,
  input  logic [NUM_CH*bl-1:0]     ch_req_len,
  input  logic [NUM_CH-1:0]        ch_req_wr_n,
  output logic [NUM_CH-1:0]        ch_req_ack,
  input  logic [NUM_CH*dw-1:0]     ch_wr_data,
  input  logic [NUM_CH*dw/8-1:0]   ch_wr_en_n,
  output logic [NUM_CH-1:0]        ch_wr_next,
  output logic [NUM_CH-1:0]        ch_rd_valid,
  output logic [NUM_CH-1:0]        ch_last_rd,
  output logic [dw-1:0]            ch_rd_data,
  output logic                     app_req,
  output logic [APP_AW-1:0]        app_req_addr,
  output logic [bl-1:0]            app_req_len,
  output logic                     app_req_wr_n,
  input  logic                     app_req_ack,
  output logic [dw-1:0]            app_wr_data,
  output logic [dw/8-1:0]          app_wr_en_n,
  input  logic                     app_wr_next_req,
  input  logic                     app_last_wr,
  input  logic                     app_rd_valid,
  input  logic                     app_last_rd,
  input  logic [dw-1:0]            app_rd_data,
  output logic                     rd_orphan
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = $clog2(RDQ_DEPTH);
  localparam int BW = dw / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WDATA
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   g_q;
  logic [CW-1:0]   w_q;
  logic [CW-1:0]   rr_ptr_q;
  logic [CW-1:0]   rr_ptr_d;
  logic            app_req_q;

  logic [CW-1:0]   tag_mem [RDQ_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW:0]     count_q;
  logic [PW:0]     count_d;
  logic            rd_orphan_q;

  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   head;
  logic            push;
  logic            pop;
  logic            accept;

  logic [NUM_CH-1:0] eligible;
  logic              grant_vld;
  logic [CW-1:0]     grant_idx;

  assign fifo_full  = (count_q == (PW+1)'(RDQ_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = tag_mem[rd_ptr_q];

  assign accept = (state_q == REQ) && app_req_ack;
  assign pop    = app_rd_valid && app_last_rd && !fifo_empty;
  // A read can only be granted with room in the FIFO; the guard keeps a
  // direction flip during REQ from overrunning it.
  assign push   = accept && app_req_wr_n && (!fifo_full || pop);

  assign rr_ptr_d = (g_q == CW'(NUM_CH - 1)) ? '0 : g_q + CW'(1);

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    eligible  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = ch_req[i] && (!ch_req_wr_n[i] || !fifo_full);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = CW'(idx);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state_q   <= IDLE;
      g_q       <= '0;
      w_q       <= '0;
      rr_ptr_q  <= '0;
      app_req_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            g_q       <= grant_idx;
            app_req_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          // The grant is held until acked, even if the requester withdraws.
          if (app_req_ack) begin
            rr_ptr_q  <= rr_ptr_d;
            app_req_q <= 1'b0;
            if (app_req_wr_n) begin
              state_q <= IDLE;
            end else begin
              w_q     <= g_q;
              state_q <= WDATA;
            end
          end
        end
        WDATA: begin
          if (app_wr_next_req && app_last_wr) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_orphan_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (app_rd_valid && fifo_empty) rd_orphan_q <= 1'b1;
    end
  end

  // NOTE: tag storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge sdram_clk) begin
    if (push) tag_mem[wr_ptr_q] <= g_q;
  end

  assign app_req      = app_req_q;
  assign app_req_addr = ch_req_addr[int'(g_q)*APP_AW +: APP_AW];
  assign app_req_len  = ch_req_len[int'(g_q)*bl +: bl];
  assign app_req_wr_n = ch_req_wr_n[g_q];
  assign app_wr_data  = (state_q == WDATA) ? ch_wr_data[int'(w_q)*dw +: dw] : '0;
  assign app_wr_en_n  = (state_q == WDATA) ? ch_wr_en_n[int'(w_q)*BW +: BW] : '1;
  assign ch_rd_data   = app_rd_data;
  assign rd_orphan    = rd_orphan_q;

  always_comb begin
    ch_req_ack  = '0;
    ch_wr_next  = '0;
    ch_rd_valid = '0;
    ch_last_rd  = '0;
    if (state_q == REQ)   ch_req_ack[g_q] = app_req_ack;
    if (state_q == WDATA) ch_wr_next[w_q] = app_wr_next_req;
    if (!fifo_empty) begin
      ch_rd_valid[head] = app_rd_valid;
      ch_last_rd[head]  = app_last_rd;
    end
  end

endmodule

// File: doc/sdrc_app_arb.md
SDRC_APP_ARB -- requirements
Module: sdrc_app_arb

Interface
REQ-001 Parameter NUM_CH, default 4, number of requestor channels (legal 2..8).
REQ-002 Parameter APP_AW, default 26, application address width.
REQ-003 Parameter dw, default 32, data width; byte enables are dw/8 bits.
REQ-004 Parameter bl, default 9, burst length width.
REQ-005 Parameter RDQ_DEPTH, default 4, outstanding-read tag FIFO depth (power of 2, 2..16).
REQ-006 Clocking: one clock, sdram_clk; reset is synchronous and active-high, sdram_rst.
REQ-007 Ports, clock and reset first:
  sdram_clk  in  1  clock
  sdram_rst  in  1  synchronous active-high reset
  ch_req  in  NUM_CH  per-channel request
  ch_req_addr  in  NUM_CH*APP_AW  packed addresses, channel i at [i*APP_AW +: APP_AW]
  ch_req_len  in  NUM_CH*bl  packed burst lengths
  ch_req_wr_n  in  NUM_CH  0 write, 1 read
  ch_req_ack  out  NUM_CH  request accepted
  ch_wr_data  in  NUM_CH*dw  packed write data
  ch_wr_en_n  in  NUM_CH*dw/8  packed active-low byte enables
  ch_wr_next  out  NUM_CH  write-data advance strobe
  ch_rd_valid  out  NUM_CH  read data valid for channel
  ch_last_rd  out  NUM_CH  last read beat for channel
  ch_rd_data  out  dw  shared read data (= app_rd_data)
  app_req  out  1  request to controller core
  app_req_addr  out  APP_AW  granted address
  app_req_len  out  bl  granted length
  app_req_wr_n  out  1  granted direction
  app_req_ack  in  1  core accepted request
  app_wr_data  out  dw  write data of write owner
  app_wr_en_n  out  dw/8  byte enables of write owner
  app_wr_next_req  in  1  core consumed a write beat
  app_last_wr  in  1  last write beat consumed
  app_rd_valid  in  1  read beat valid
  app_last_rd  in  1  last read beat
  app_rd_data  in  dw  read data
  rd_orphan  out  1  sticky: read beat with empty tag FIFO

Function
REQ-010 FSM states IDLE, REQ, WDATA.
REQ-011 IDLE: eligible channel = ch_req[i]=1 and (ch_req_wr_n[i]=0 or tag FIFO not full); if any, latch grant g via round-robin starting at rr_ptr, enter REQ next cycle.
REQ-012 REQ: app_req=1; app_req_addr/len/wr_n muxed from latched g (live values); ch_req_ack[g]=app_req_ack combinationally; all other ch_req_ack=0.
REQ-013 REQ and app_req_ack=1: rr_ptr<=(g+1) mod NUM_CH; read -> push g into tag FIFO, go IDLE; write -> latch owner w=g, go WDATA.
REQ-014 REQ without ack: hold g and app_req=1 indefinitely, even if ch_req[g] drops (protocol violation, not arbitrated away).
REQ-015 WDATA: app_wr_data/app_wr_en_n muxed from owner w; ch_wr_next[w]=app_wr_next_req; no new grant; app_wr_next_req=1 and app_last_wr=1 -> IDLE.
REQ-016 Outside WDATA: app_wr_data=0, app_wr_en_n all ones, ch_wr_next=0.
REQ-017 Read return: head h of tag FIFO; ch_rd_valid[h]=app_rd_valid, ch_last_rd[h]=app_last_rd, others 0; pop on app_rd_valid and app_last_rd.
REQ-018 Simultaneous push and pop: count unchanged, both pointers advance; pop precedes push when FIFO full is not reached (full blocks read grants at IDLE only).
REQ-019 app_rd_valid=1 with FIFO empty: all ch_rd_valid=0, no pop, rd_orphan<=1 (sticky until reset).
REQ-020 Minimum request latency: ch_req rise to app_req = 1 cycle; back-to-back grants separated by one IDLE cycle.
REQ-021 Pointer widths: clog2(RDQ_DEPTH) with wrap; count width clog2(RDQ_DEPTH)+1.

Reset
REQ-030 sdram_rst=1 at rising edge: state IDLE, rr_ptr=0, g=w=0, FIFO empty, rd_orphan=0, app_req=0, all ch_req_ack/ch_wr_next/ch_rd_valid/ch_last_rd=0, app_wr_en_n all ones.
REQ-031 Reset mid-burst abandons grant and tag FIFO contents; no outputs asserted during reset cycle's following cycle.

Verification
REQ-040 All four channels request reads simultaneously, ack immediately -> grants 0,1,2,3 in order, FIFO holds 0,1,2,3; returns routed ch_rd_valid[0..3] in that order.
REQ-041 Ch2 write len=4, ack on cycle 3 -> WDATA; four app_wr_next_req pulses reach ch_wr_next[2] only; ch1 request held off until app_last_wr.
REQ-042 RDQ_DEPTH=4, five read requests without returns -> fifth not granted until first app_last_rd pops; writes still granted meanwhile.
REQ-043 app_rd_valid with FIFO empty after reset -> rd_orphan=1, no ch_rd_valid, stays 1 until sdram_rst.
REQ-044 Push and pop same cycle at count=2 -> count stays 2, routing order preserved.
REQ-045 sdram_rst asserted in WDATA -> next cycle IDLE, app_req=0, FIFO empty, rr_ptr=0.
